mem_wb_stage_reg: RTL and testbench
===================================

Name: mem_wb_stage_reg

Overview:
- Parametrised MEM/WB pipeline register for the pipelined MIPS core. It sits between the data-memory stage and the register-file write port.
- Adds a valid bit, stall and flush control, and a debug-unit enable gate for step mode.
- Adds a registered write-back data select, a sticky halt flag and a saturating retired-instruction counter, all read by the debug unit.

Parameters:
- NBITS, 32, data/result/PC width in bits.
- RBITS, 5, register-name width.
- CBITS, 32, retired-instruction counter width.

Ports:
- i_clk  in  1  system clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  debug-unit run/step enable; 0 freezes the whole block.
- i_stall  in  1  hold current WB contents.
- i_flush  in  1  load a bubble into WB.
- i_cnt_clr  in  1  synchronous clear of o_retired.
- MEM_valid  in  1  MEM stage holds a real instruction.
- MEM_result  in  NBITS  ALU result.
- MEM_data  in  NBITS  data-memory read data.
- MEM_rd  in  RBITS  destination register.
- MEM_pc  in  NBITS  instruction PC.
- MEM_regwrite  in  1  instruction writes the register file.
- MEM_memtoreg  in  1  write-back source is memory data.
- MEM_halt  in  1  instruction is HALT.
- WB_valid  out  1  WB holds a real instruction.
- WB_result  out  NBITS  registered ALU result.
- WB_data  out  NBITS  registered memory data.
- WB_rd  out  RBITS  registered destination register.
- WB_pc  out  NBITS  registered PC.
- WB_regwrite  out  1  qualified register-file write enable.
- WB_memtoreg  out  1  registered source select.
- WB_wdata  out  NBITS  write-back value = WB_memtoreg ? WB_data : WB_result.
- o_halted  out  1  sticky: a HALT has reached WB.
- o_retired  out  CBITS  count of valid instructions entered into WB.

Behaviour:
- Reset (i_rst_n=0, asynchronous, any time including mid-operation): every registered output goes to 0, i.e. WB_valid, WB_result, WB_data, WB_rd, WB_pc, WB_regwrite, WB_memtoreg, o_halted and o_retired. WB_wdata is therefore 0. Release takes effect at the next rising edge.
- Per-edge priority, highest first: reset; i_enable=0; o_halted=1; i_flush; i_stall; load.
  - i_enable=0: all state, counter included, holds. i_cnt_clr is ignored.
  - o_halted=1: pipeline fields hold. Only reset clears o_halted. i_cnt_clr still works.
  - i_flush=1: bubble. WB_valid, WB_regwrite and WB_memtoreg go to 0. WB_result, WB_data, WB_rd and WB_pc go to 0. Flush beats a simultaneous stall.
  - i_stall=1: all fields hold and the counter does not increment.
  - Load: every MEM_* field is captured.
    - WB_valid <= MEM_valid.
    - WB_regwrite <= MEM_regwrite & MEM_valid & (MEM_rd != 0).
    - WB_memtoreg <= MEM_memtoreg & MEM_valid.
- Latency: one cycle, MEM inputs to WB outputs. WB_wdata is combinational from the WB registers; there is no extra register.
- Halt: on a load edge with MEM_valid=1 and MEM_halt=1, o_halted is set at that same edge. The HALT counts as retired; its regwrite is handled normally.
- Counter:
  - On a load edge with MEM_valid=1, o_retired increments by 1 and saturates at 2^CBITS-1 (no wrap).
  - i_cnt_clr=1 (with i_enable=1) sets o_retired to 0 and overrides a same-edge increment.
- The stage never checks or gates a flush or stall that arrives with MEM_valid=0.
- Step mode: a single i_enable=1 cycle advances the stage exactly one edge under the rules above.

Decomposition:
- Shared package/include: pipeline field width constants (NBITS, RBITS) and register 0 encoding (5'd0).
- Natural sub-module: sat_counter, a CBITS-wide saturating counter with inc, clr and en inputs, instantiated for o_retired.
- Everything else stays inline.

Test Plan:
- Reset mid-run: load MEM_result=0x12345678, MEM_rd=5, MEM_regwrite=1, then drop i_rst_n between edges → all outputs 0 immediately, without waiting for a clock edge. o_retired=0.
- Load and write-back select: MEM_valid=1, result=0xA, data=0xB, rd=3, memtoreg=1 → next cycle WB_wdata=0xB, WB_regwrite=1, o_retired=1. Repeat with memtoreg=0 → WB_wdata=0xA, o_retired=2.
- Register-0 qualification: MEM_rd=0, MEM_regwrite=1, MEM_valid=1 → WB_regwrite=0 and WB_valid=1.
- Stall/flush: stall for 3 cycles → WB fields unchanged and o_retired unchanged. Assert stall+flush together → WB_valid=0, WB_regwrite=0, fields 0.
- Debug gating: i_enable=0 with new MEM values and i_cnt_clr=1 → nothing changes. One-cycle i_enable pulse → exactly one load.
- Halt and saturation:
  - Valid HALT → o_halted=1 at the same load edge. Later MEM inputs are ignored and o_retired stays frozen.
  - Separately, with CBITS=2, 5 valid loads → o_retired=3.

Source files
------------

// File: rtl/mem_wb_stage_reg_pkg.sv
// Shared constants for the MEM/WB pipeline register: default field widths
// and the encoding of the hard-wired zero register.
package mem_wb_stage_reg_pkg;

    localparam int unsigned NBITS_DEF = 32;
    localparam int unsigned RBITS_DEF = 5;
    localparam int unsigned CBITS_DEF = 32;

    localparam logic [RBITS_DEF-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mem_wb_stage_reg_sat_counter.sv
// CBITS-wide saturating up-counter with enable, synchronous clear and increment.
module sat_counter #(
    parameter int unsigned CBITS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             inc,
    output logic [CBITS-1:0] count
);

    function automatic logic [CBITS-1:0] sat_inc(input logic [CBITS-1:0] value);
        if (&value) begin
            return value;
        end
        return value + CBITS'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            // Clear wins over a same-edge increment.
            if (clr) begin
                count <= '0;
            end else if (inc) begin
                count <= sat_inc(count);
            end
        end
    end

endmodule

// File: rtl/mem_wb_stage_reg.sv
// MEM/WB pipeline register with valid/stall/flush, debug enable gating,
// write-back data select, sticky halt flag and retired-instruction counter.
module mem_wb_stage_reg
    import mem_wb_stage_reg_pkg::*;
#(
    parameter int unsigned NBITS = NBITS_DEF,
    parameter int unsigned RBITS = RBITS_DEF,
    parameter int unsigned CBITS = CBITS_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic             i_cnt_clr,
    input  logic             MEM_valid,
    input  logic [NBITS-1:0] MEM_result,
    input  logic [NBITS-1:0] MEM_data,
    input  logic [RBITS-1:0] MEM_rd,
    input  logic [NBITS-1:0] MEM_pc,
    input  logic             MEM_regwrite,
    input  logic             MEM_memtoreg,
    input  logic             MEM_halt,
    output logic             WB_valid,
    output logic [NBITS-1:0] WB_result,
    output logic [NBITS-1:0] WB_data,
    output logic [RBITS-1:0] WB_rd,
    output logic [NBITS-1:0] WB_pc,
    output logic             WB_regwrite,
    output logic             WB_memtoreg,
    output logic [NBITS-1:0] WB_wdata,
    output logic             o_halted,
    output logic [CBITS-1:0] o_retired
);

    logic advance;
    logic load;

    // Once halted, the pipeline fields freeze until reset.
    assign advance = i_enable && !o_halted;
    assign load    = advance && !i_flush && !i_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            WB_valid    <= 1'b0;
            WB_result   <= '0;
            WB_data     <= '0;
            WB_rd       <= '0;
            WB_pc       <= '0;
            WB_regwrite <= 1'b0;
            WB_memtoreg <= 1'b0;
            o_halted    <= 1'b0;
        end else if (advance) begin
            if (i_flush) begin
                WB_valid    <= 1'b0;
                WB_result   <= '0;
                WB_data     <= '0;
                WB_rd       <= '0;
                WB_pc       <= '0;
                WB_regwrite <= 1'b0;
                WB_memtoreg <= 1'b0;
            end else if (!i_stall) begin
                WB_valid    <= MEM_valid;
                WB_result   <= MEM_result;
                WB_data     <= MEM_data;
                WB_rd       <= MEM_rd;
                WB_pc       <= MEM_pc;
                // Writes to the zero register are dropped here so WB never
                // needs to look at the destination name.
                WB_regwrite <= MEM_regwrite && MEM_valid && (MEM_rd != RBITS'(REG_ZERO));
                WB_memtoreg <= MEM_memtoreg && MEM_valid;
                if (MEM_valid && MEM_halt) begin
                    o_halted <= 1'b1;
                end
            end
        end
    end

    assign WB_wdata = WB_memtoreg ? WB_data : WB_result;

    sat_counter #(
        .CBITS(CBITS)
    ) u_retired (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (i_enable),
        .clr   (i_cnt_clr),
        .inc   (load && MEM_valid),
        .count (o_retired)
    );

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// Directed bench for mem_wb_stage_reg: table of per-cycle vectors plus
// hand-written asynchronous reset sequences; a CBITS=2 copy checks saturation.
module tb_mem_wb_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, stall, flush, cnt_clr;
    logic        m_valid, m_regwrite, m_memtoreg, m_halt;
    logic [31:0] m_result, m_data, m_pc;
    logic [4:0]  m_rd;

    logic        wb_valid, wb_regwrite, wb_memtoreg, halted;
    logic [31:0] wb_result, wb_data, wb_pc, wb_wdata, retired;
    logic [4:0]  wb_rd;

    logic        s_valid, s_regwrite, s_memtoreg, s_halted;
    logic [31:0] s_result, s_data, s_pc, s_wdata;
    logic [4:0]  s_rd;
    logic [1:0]  s_retired;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_wb_stage_reg dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_stall(stall),
        .i_flush(flush), .i_cnt_clr(cnt_clr), .MEM_valid(m_valid),
        .MEM_result(m_result), .MEM_data(m_data), .MEM_rd(m_rd), .MEM_pc(m_pc),
        .MEM_regwrite(m_regwrite), .MEM_memtoreg(m_memtoreg), .MEM_halt(m_halt),
        .WB_valid(wb_valid), .WB_result(wb_result), .WB_data(wb_data),
        .WB_rd(wb_rd), .WB_pc(wb_pc), .WB_regwrite(wb_regwrite),
        .WB_memtoreg(wb_memtoreg), .WB_wdata(wb_wdata), .o_halted(halted),
        .o_retired(retired)
    );

    mem_wb_stage_reg #(.CBITS(2)) dut_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_stall(stall),
        .i_flush(flush), .i_cnt_clr(cnt_clr), .MEM_valid(m_valid),
        .MEM_result(m_result), .MEM_data(m_data), .MEM_rd(m_rd), .MEM_pc(m_pc),
        .MEM_regwrite(m_regwrite), .MEM_memtoreg(m_memtoreg), .MEM_halt(m_halt),
        .WB_valid(s_valid), .WB_result(s_result), .WB_data(s_data),
        .WB_rd(s_rd), .WB_pc(s_pc), .WB_regwrite(s_regwrite),
        .WB_memtoreg(s_memtoreg), .WB_wdata(s_wdata), .o_halted(s_halted),
        .o_retired(s_retired)
    );

    typedef struct {
        logic        en, st, fl, clr, v, rw, m2r, h;
        logic [31:0] res, dat, pc;
        logic [4:0]  rd;
        logic        e_v, e_rw, e_m2r, e_h;
        logic [31:0] e_res, e_dat, e_pc, e_wd, e_ret;
        logic [4:0]  e_rd;
        logic [1:0]  e_sm;
    } vec_t;

    localparam int NV = 19;
    vec_t vt[NV];

    task automatic set_in(input int i, input logic en, st, fl, clr, v,
                          input logic [31:0] res, dat, input logic [4:0] rd,
                          input logic [31:0] pc, input logic rw, m2r, h);
        vt[i].en = en;  vt[i].st = st;   vt[i].fl = fl;   vt[i].clr = clr;
        vt[i].v = v;    vt[i].res = res; vt[i].dat = dat; vt[i].rd = rd;
        vt[i].pc = pc;  vt[i].rw = rw;   vt[i].m2r = m2r; vt[i].h = h;
    endtask

    task automatic set_exp(input int i, input logic v, input logic [31:0] res, dat,
                           input logic [4:0] rd, input logic [31:0] pc,
                           input logic rw, m2r, input logic [31:0] wd,
                           input logic h, input logic [31:0] ret, input logic [1:0] sm);
        vt[i].e_v = v;   vt[i].e_res = res; vt[i].e_dat = dat; vt[i].e_rd = rd;
        vt[i].e_pc = pc; vt[i].e_rw = rw;   vt[i].e_m2r = m2r; vt[i].e_wd = wd;
        vt[i].e_h = h;   vt[i].e_ret = ret; vt[i].e_sm = sm;
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " WB_valid"},    0, {31'd0, wb_valid},    32'd0);
        chk({tag, " WB_result"},   0, wb_result,            32'd0);
        chk({tag, " WB_data"},     0, wb_data,              32'd0);
        chk({tag, " WB_rd"},       0, {27'd0, wb_rd},       32'd0);
        chk({tag, " WB_pc"},       0, wb_pc,                32'd0);
        chk({tag, " WB_regwrite"}, 0, {31'd0, wb_regwrite}, 32'd0);
        chk({tag, " WB_memtoreg"}, 0, {31'd0, wb_memtoreg}, 32'd0);
        chk({tag, " WB_wdata"},    0, wb_wdata,             32'd0);
        chk({tag, " o_halted"},    0, {31'd0, halted},      32'd0);
        chk({tag, " o_retired"},   0, retired,              32'd0);
        chk({tag, " small o_retired"}, 0, {30'd0, s_retired}, 32'd0);
    endtask

    task automatic drive(input logic en, st, fl, clr, v, input logic [31:0] res, dat,
                         input logic [4:0] rd, input logic [31:0] pc,
                         input logic rw, m2r, h);
        enable = en; stall = st; flush = fl; cnt_clr = clr; m_valid = v;
        m_result = res; m_data = dat; m_rd = rd; m_pc = pc;
        m_regwrite = rw; m_memtoreg = m2r; m_halt = h;
    endtask

    initial begin
        //        i   en st fl cl v  result        data          rd    pc            rw m2r h
        set_in( 0, 1, 0, 0, 0, 1, 32'hA,        32'hB,        5'd3, 32'h100,      1, 1, 0);
        set_exp(0, 1, 32'hA, 32'hB, 5'd3, 32'h100, 1, 1, 32'hB, 0, 1, 1);
        set_in( 1, 1, 0, 0, 0, 1, 32'hA,        32'hB,        5'd3, 32'h104,      1, 0, 0);
        set_exp(1, 1, 32'hA, 32'hB, 5'd3, 32'h104, 1, 0, 32'hA, 0, 2, 2);
        set_in( 2, 1, 0, 0, 0, 1, 32'hC,        32'hD,        5'd0, 32'h108,      1, 0, 0);
        set_exp(2, 1, 32'hC, 32'hD, 5'd0, 32'h108, 0, 0, 32'hC, 0, 3, 3);
        set_in( 3, 1, 0, 0, 0, 1, 32'h11,       32'h22,       5'd7, 32'h10C,      1, 1, 0);
        set_exp(3, 1, 32'h11, 32'h22, 5'd7, 32'h10C, 1, 1, 32'h22, 0, 4, 3);
        set_in( 4, 1, 0, 0, 0, 1, 32'h33,       32'h44,       5'd8, 32'h110,      0, 0, 0);
        set_exp(4, 1, 32'h33, 32'h44, 5'd8, 32'h110, 0, 0, 32'h33, 0, 5, 3);
        for (int i = 5; i < 8; i++) begin
            set_in( i, 1, 1, 0, 0, 1, 32'h55, 32'h56, 5'd9, 32'h200, 1, 1, 0);
            set_exp(i, 1, 32'h33, 32'h44, 5'd8, 32'h110, 0, 0, 32'h33, 0, 5, 3);
        end
        set_in( 8, 1, 1, 1, 0, 1, 32'h57,       32'h58,       5'd9, 32'h204,      1, 1, 0);
        set_exp(8, 0, 32'h0, 32'h0, 5'd0, 32'h0, 0, 0, 32'h0, 0, 5, 3);
        set_in( 9, 1, 0, 0, 0, 0, 32'h66,       32'h77,       5'd4, 32'h114,      1, 1, 0);
        set_exp(9, 0, 32'h66, 32'h77, 5'd4, 32'h114, 0, 0, 32'h66, 0, 5, 3);
        set_in(10, 0, 0, 0, 1, 1, 32'h99,       32'h9A,       5'd1, 32'h300,      1, 1, 1);
        set_exp(10, 0, 32'h66, 32'h77, 5'd4, 32'h114, 0, 0, 32'h66, 0, 5, 3);
        set_in(11, 1, 0, 0, 1, 1, 32'h88,       32'h99,       5'd2, 32'h118,      1, 0, 0);
        set_exp(11, 1, 32'h88, 32'h99, 5'd2, 32'h118, 1, 0, 32'h88, 0, 0, 0);
        set_in(12, 0, 0, 0, 0, 1, 32'hAA,       32'hAB,       5'd5, 32'h304,      1, 1, 0);
        set_exp(12, 1, 32'h88, 32'h99, 5'd2, 32'h118, 1, 0, 32'h88, 0, 0, 0);
        set_in(13, 1, 0, 0, 0, 1, 32'hBB,       32'hCC,       5'd6, 32'h11C,      1, 1, 0);
        set_exp(13, 1, 32'hBB, 32'hCC, 5'd6, 32'h11C, 1, 1, 32'hCC, 0, 1, 1);
        set_in(14, 0, 0, 0, 0, 1, 32'hDE,       32'hDF,       5'd7, 32'h308,      1, 0, 0);
        set_exp(14, 1, 32'hBB, 32'hCC, 5'd6, 32'h11C, 1, 1, 32'hCC, 0, 1, 1);
        set_in(15, 1, 0, 0, 0, 1, 32'hDD,       32'h0,        5'd0, 32'h120,      0, 0, 1);
        set_exp(15, 1, 32'hDD, 32'h0, 5'd0, 32'h120, 0, 0, 32'hDD, 1, 2, 2);
        set_in(16, 1, 0, 0, 0, 1, 32'hEE,       32'hEF,       5'd9, 32'h124,      1, 1, 0);
        set_exp(16, 1, 32'hDD, 32'h0, 5'd0, 32'h120, 0, 0, 32'hDD, 1, 2, 2);
        set_in(17, 1, 0, 1, 0, 1, 32'hF0,       32'hF1,       5'd9, 32'h128,      1, 1, 0);
        set_exp(17, 1, 32'hDD, 32'h0, 5'd0, 32'h120, 0, 0, 32'hDD, 1, 2, 2);
        set_in(18, 1, 0, 0, 1, 1, 32'hF2,       32'hF3,       5'd9, 32'h12C,      1, 1, 0);
        set_exp(18, 1, 32'hDD, 32'h0, 5'd0, 32'h120, 0, 0, 32'hDD, 1, 0, 0);

        rst_n = 1'b0;
        drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 0, 0, 0);
        #2;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vt[i].en, vt[i].st, vt[i].fl, vt[i].clr, vt[i].v, vt[i].res,
                  vt[i].dat, vt[i].rd, vt[i].pc, vt[i].rw, vt[i].m2r, vt[i].h);
            @(posedge clk);
            #1;
            chk("WB_valid",    i, {31'd0, wb_valid},    {31'd0, vt[i].e_v});
            chk("WB_result",   i, wb_result,            vt[i].e_res);
            chk("WB_data",     i, wb_data,              vt[i].e_dat);
            chk("WB_rd",       i, {27'd0, wb_rd},       {27'd0, vt[i].e_rd});
            chk("WB_pc",       i, wb_pc,                vt[i].e_pc);
            chk("WB_regwrite", i, {31'd0, wb_regwrite}, {31'd0, vt[i].e_rw});
            chk("WB_memtoreg", i, {31'd0, wb_memtoreg}, {31'd0, vt[i].e_m2r});
            chk("WB_wdata",    i, wb_wdata,             vt[i].e_wd);
            chk("o_halted",    i, {31'd0, halted},      {31'd0, vt[i].e_h});
            chk("o_retired",   i, retired,              vt[i].e_ret);
            chk("small o_retired", i, {30'd0, s_retired}, {30'd0, vt[i].e_sm});
        end

        // Asynchronous reset while halted, seen before any clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("reset while halted");
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 1, 32'h12345678, 32'h0, 5'd5, 32'h400, 1, 0, 0);
        @(posedge clk);
        #1;
        chk("post-reset WB_result",   0, wb_result,            32'h12345678);
        chk("post-reset WB_regwrite", 0, {31'd0, wb_regwrite}, 32'd1);
        chk("post-reset o_retired",   0, retired,              32'd1);
        // Drop reset mid-cycle: outputs must clear without an edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("reset mid-cycle");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
